// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory with a program write port and a one-entry
// registered fetch response. Faulted fetches return NOP_WORD and are counted.
module instr_mem_sync #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          AW          = 32,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic          rsp_fault,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  output logic [15:0]   fault_cnt
);

  localparam int IW = $clog2(DEPTH_WORDS);

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_data;
  logic          r_rsp_fault;
  logic [15:0]   r_fault_cnt;

  logic          w_req_oor;
  logic          w_prog_oor;
  logic [IW-1:0] w_req_idx;
  logic [IW-1:0] w_prog_idx;
  logic          w_req_fault;
  logic          w_prog_ok;
  logic          w_accept;

  // Any address bit above the word index means the address is past the array.
  generate
    if (AW > IW + 2) begin : g_hi_bits
      assign w_req_oor  = |req_addr[AW-1:IW+2];
      assign w_prog_oor = |prog_addr[AW-1:IW+2];
    end else begin : g_no_hi_bits
      assign w_req_oor  = 1'b0;
      assign w_prog_oor = 1'b0;
    end
  endgenerate

  assign w_req_idx   = req_addr[IW+1:2];
  assign w_prog_idx  = prog_addr[IW+1:2];
  assign w_req_fault = (req_addr[1:0] != 2'b00) || w_req_oor;
  assign w_prog_ok   = prog_we && !rst && (prog_addr[1:0] == 2'b00) && !w_prog_oor;

  assign req_ready = !rst && (!r_rsp_valid || rsp_ready);
  assign w_accept  = req_valid && req_ready;

  // Read and write share the edge; nonblocking semantics give read-first.
  always_ff @(posedge clk) begin
    if (w_prog_ok) begin
      r_mem[w_prog_idx] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'h0;
      r_rsp_fault <= 1'b0;
      r_fault_cnt <= 16'h0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_fault <= w_req_fault;
      r_rsp_data  <= w_req_fault ? NOP_WORD : r_mem[w_req_idx];
      if (w_req_fault && (r_fault_cnt != 16'hFFFF)) begin
        r_fault_cnt <= r_fault_cnt + 16'd1;
      end
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_fault = r_rsp_fault;
  assign fault_cnt = r_fault_cnt;

endmodule

// File: doc/instr_mem_sync.md
INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter DEPTH_WORDS, default 1024: number of 32-bit instruction words stored; power of two, at least 4.
REQ-003 Parameter AW, default 32: width of the byte address.
REQ-004 Parameter NOP_WORD, default 32'h00000013: word returned on a faulted fetch.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  1  fetch request present.
REQ-008 req_ready  out  1  block accepts a request this cycle.
REQ-009 req_addr  in  AW  byte address of the fetch.
REQ-010 rsp_valid  out  1  response held on rsp_data/rsp_fault.
REQ-011 rsp_ready  in  1  consumer takes the response this cycle.
REQ-012 rsp_data  out  32  fetched instruction word, little-endian.
REQ-013 rsp_fault  out  1  fetch was misaligned or out of range.
REQ-014 prog_we  in  1  program-port word write strobe.
REQ-015 prog_addr  in  AW  byte address for the program write.
REQ-016 prog_data  in  32  word to write.
REQ-017 fault_cnt  out  16  count of faulted responses issued.

Function
REQ-018 Storage SHALL be an array of DEPTH_WORDS 32-bit words; word index = req_addr[log2(DEPTH_WORDS)+1:2].
REQ-019 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-020 req_ready SHALL equal (!rsp_valid || rsp_ready), giving a one-entry output register with full throughput.
REQ-021 The latency SHALL be one cycle: after an accept at edge N, rsp_valid=1 and the response are visible after edge N.
REQ-022 While rsp_valid=1 and rsp_ready=0, rsp_data, rsp_fault and rsp_valid SHALL hold unchanged.
REQ-023 On an edge with rsp_ready=1 and no accept, rsp_valid SHALL go to 0; a response consumed with a simultaneous accept SHALL be replaced by the new response, with no bubble.
REQ-024 A misaligned fetch (req_addr[1:0]!=0) SHALL produce rsp_fault=1 and rsp_data=NOP_WORD.
REQ-025 An out-of-range fetch (req_addr >= 4*DEPTH_WORDS) SHALL produce rsp_fault=1 and rsp_data=NOP_WORD; the index SHALL NOT wrap.
REQ-026 A non-faulted fetch SHALL produce rsp_fault=0 and the stored word.
REQ-027 prog_we=1 SHALL write prog_data at the word prog_addr[log2(DEPTH_WORDS)+1:2] on the edge. The write SHALL be ignored if prog_addr is misaligned or out of range.
REQ-028 When a write and a fetch to the same word occur on the same edge, the fetch SHALL return the old word (read-first).
REQ-029 fault_cnt SHALL increment by 1 on each accepted faulted request and SHALL saturate at 16'hFFFF.
REQ-030 Program writes SHALL be independent of the handshake state and SHALL never stall fetches.

Reset
REQ-031 While rst=1: rsp_valid=0, rsp_data=0, rsp_fault=0 and fault_cnt=0 after the edge, and no request SHALL be accepted (req_ready=0).
REQ-032 A response pending when reset asserts SHALL be discarded.
REQ-033 Memory contents SHALL NOT be altered by reset, and prog_we SHALL be ignored while rst=1.

Verification
REQ-034 Write 32'hDEADC037 at 0x0 and 32'h00000013 at 0x4 via the program port, then fetch 0x0 and 0x4 back to back with rsp_ready=1 -> responses on consecutive cycles, data DEADC037 then 00000013, fault=0.
REQ-035 Fetch 0x0 with rsp_ready=0 for 3 cycles -> rsp_valid stays 1 and data is stable; req_ready=0 throughout; after rsp_ready=1 the next request is accepted on that same edge.
REQ-036 Fetch 0x2, then fetch 4*DEPTH_WORDS -> two responses with fault=1, data 00000013, fault_cnt=2; memory at word 0 is unchanged.
REQ-037 Program-write 0x11111111 at 0x8 on the same edge as a fetch of 0x8 (old value 0x22222222) -> the response is 22222222; a following fetch of 0x8 returns 11111111.
REQ-038 Assert rst for one cycle while a response is stalled -> rsp_valid=0 and fault_cnt=0 after the edge; a later fetch returns the pre-reset stored word.
